// File: rtl/bkram_sd_ctrl.sv
// rtl/bkram_sd_ctrl.sv - backup-RAM persistence controller: slot load/save over SD sectors, format, autosave, watchdog
module bkram_sd_ctrl #(
  parameter int           SECT_LOG2 = 4,
  parameter int           SLOT_W    = 2,
  parameter int           FMT_WORDS = 4,
  parameter logic [127:0] FMT_PAT   = 128'h0000_0000_0000_0000_8010_8800_4D42_5548,
  parameter bit           FMT_CLEAR = 1'b1,
  parameter int           TO_LOG2   = 24
) (
  input  logic                   i_clk_sys,
  input  logic                   i_reset_n,
  input  logic                   i_downloading,
  input  logic                   i_img_mounted,
  input  logic                   i_img_readonly,
  input  logic                   i_img_size_nz,
  input  logic [SLOT_W-1:0]      i_slot,
  input  logic                   i_load_req,
  input  logic                   i_save_req,
  input  logic                   i_format_req,
  input  logic                   i_autosave_en,
  input  logic                   i_autosave_trig,
  input  logic                   i_bram_wr,
  output logic [31:0]            o_sd_lba,
  output logic                   o_sd_rd,
  output logic                   o_sd_wr,
  input  logic                   i_sd_ack,
  output logic [SECT_LOG2+7:0]   o_fmt_addr,
  output logic [15:0]            o_fmt_data,
  output logic                   o_fmt_we,
  output logic                   o_fmt_sel,
  output logic                   o_bk_ena,
  output logic                   o_bk_loading,
  output logic                   o_bk_busy,
  output logic                   o_dirty,
  output logic                   o_err
);

  localparam int AW       = SECT_LOG2 + 8;
  localparam int LAST_FMT = FMT_CLEAR ? (2 ** AW) - 1 : FMT_WORDS - 1;

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_ACK, S_FMT} state_t;

  state_t                r_state, w_next;
  logic                  r_dl_q, r_load_q, r_save_q, r_fmt_q, r_trig_q, r_ack_q;
  logic                  r_bk_ena, r_dirty, r_err, r_is_load;
  logic [SLOT_W-1:0]     r_slot;
  logic [SECT_LOG2-1:0]  r_sector;
  logic [TO_LOG2-1:0]    r_wd;
  logic [AW-1:0]         r_fmt_addr;

  logic w_load_edge, w_save_edge, w_fmt_edge, w_trig_edge, w_ack_rise, w_ack_fall;
  logic w_auto, w_wd_ovf, w_xfer;
  logic w_go_xfer, w_go_load, w_go_fmt, w_next_sector, w_xfer_done, w_abort, w_fmt_done;
  logic [2:0] w_hdr_idx;

  assign w_load_edge = i_load_req & ~r_load_q;
  assign w_save_edge = i_save_req & ~r_save_q;
  assign w_fmt_edge  = i_format_req & ~r_fmt_q;
  assign w_trig_edge = i_autosave_trig & ~r_trig_q;
  assign w_ack_rise  = i_sd_ack & ~r_ack_q;
  assign w_ack_fall  = ~i_sd_ack & r_ack_q;
  assign w_auto      = i_autosave_en & r_dirty & w_trig_edge;
  assign w_wd_ovf    = &r_wd;
  assign w_xfer      = (r_state == S_REQ) || (r_state == S_ACK);

  always_comb begin
    w_next        = r_state;
    w_go_xfer     = 1'b0;
    w_go_load     = 1'b0;
    w_go_fmt      = 1'b0;
    w_next_sector = 1'b0;
    w_xfer_done   = 1'b0;
    w_abort       = 1'b0;
    w_fmt_done    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_fmt_edge) begin
          w_go_fmt = 1'b1;
          w_next   = S_FMT;
        end else if (r_bk_ena && (w_load_edge || w_save_edge || w_auto)) begin
          w_go_xfer = 1'b1;
          w_go_load = w_load_edge;
          w_next    = S_REQ;
        end
      end
      S_REQ: begin
        if (w_ack_rise) begin
          w_next = S_ACK;
        end else if (w_wd_ovf) begin
          w_abort = 1'b1;
          w_next  = S_IDLE;
        end
      end
      S_ACK: begin
        if (w_ack_fall) begin
          if (&r_sector) begin
            w_xfer_done = 1'b1;
            w_next      = S_IDLE;
          end else begin
            w_next_sector = 1'b1;
            w_next        = S_REQ;
          end
        end else if (w_wd_ovf) begin
          w_abort = 1'b1;
          w_next  = S_IDLE;
        end
      end
      S_FMT: begin
        if (r_fmt_addr == AW'(LAST_FMT)) begin
          w_fmt_done = 1'b1;
          w_next     = S_IDLE;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk_sys or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state    <= S_IDLE;
      r_dl_q     <= 1'b0;
      r_load_q   <= 1'b0;
      r_save_q   <= 1'b0;
      r_fmt_q    <= 1'b0;
      r_trig_q   <= 1'b0;
      r_ack_q    <= 1'b0;
      r_bk_ena   <= 1'b0;
      r_dirty    <= 1'b0;
      r_err      <= 1'b0;
      r_is_load  <= 1'b0;
      r_slot     <= '0;
      r_sector   <= '0;
      r_wd       <= '0;
      r_fmt_addr <= '0;
    end else begin
      r_state  <= w_next;
      r_dl_q   <= i_downloading;
      r_load_q <= i_load_req;
      r_save_q <= i_save_req;
      r_fmt_q  <= i_format_req;
      r_trig_q <= i_autosave_trig;
      r_ack_q  <= i_sd_ack;

      if (i_downloading && !r_dl_q) r_bk_ena <= 1'b0;
      if (i_downloading && i_img_mounted && i_img_size_nz && !i_img_readonly) r_bk_ena <= 1'b1;

      if (w_go_xfer) begin
        r_sector  <= '0;
        r_slot    <= i_slot;
        r_is_load <= w_go_load;
      end else if (w_next_sector) begin
        r_sector <= r_sector + 1'b1;
      end

      // Watchdog restarts on every request assert and every ack edge.
      if (w_go_xfer || w_next_sector || w_ack_rise || w_ack_fall) r_wd <= '0;
      else if (w_xfer)                                            r_wd <= r_wd + 1'b1;

      if (w_go_xfer || w_go_fmt) r_err <= 1'b0;
      else if (w_abort)          r_err <= 1'b1;

      if (w_go_fmt)            r_fmt_addr <= '0;
      else if (r_state == S_FMT) r_fmt_addr <= r_fmt_addr + 1'b1;

      // Set sources are ordered last so a same-cycle core write keeps dirty high.
      if ((w_go_xfer && !w_go_load) || (w_xfer_done && r_is_load)) r_dirty <= 1'b0;
      if (i_bram_wr || w_fmt_done)                                 r_dirty <= 1'b1;
    end
  end

  assign w_hdr_idx    = r_fmt_addr[2:0];
  assign o_sd_lba     = 32'({r_slot, r_sector});
  assign o_sd_rd      = (r_state == S_REQ) && r_is_load;
  assign o_sd_wr      = (r_state == S_REQ) && !r_is_load;
  assign o_fmt_addr   = r_fmt_addr;
  assign o_fmt_we     = (r_state == S_FMT);
  assign o_fmt_sel    = (r_state == S_FMT);
  assign o_fmt_data   = ((r_state == S_FMT) && (r_fmt_addr < AW'(FMT_WORDS)))
                        ? FMT_PAT[{w_hdr_idx, 4'b0000} +: 16] : 16'h0000;
  assign o_bk_ena     = r_bk_ena;
  assign o_bk_loading = w_xfer && r_is_load;
  assign o_bk_busy    = (r_state != S_IDLE);
  assign o_dirty      = r_dirty;
  assign o_err        = r_err;

endmodule
